// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: groups the hazard detection inputs and the pipeline control outputs.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

interface hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_ex_memread;
    logic [4:0]  id_ex_rt;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_write;
    logic        ex_mem_write;
    logic        id_ex_bubble;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mem_timeout;
    logic [15:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_ex_memread, id_ex_rt, branch_taken, mem_req, mem_ready,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble,
               if_id_flush, id_ex_flush, mem_timeout, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_ex_memread, id_ex_rt, branch_taken, mem_req, mem_ready,
        output pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble,
               if_id_flush, id_ex_flush, mem_timeout, stall_cycles
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl: pipeline hazard unit -- load-use stall, branch flush, memory
// freeze with timeout halt, and a saturating stall-cycle counter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module hazard_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  wire             clk,
    input  wire             reset,
    hazard_ctrl_if.slave    hif
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic        r_mem_timeout;
    logic [15:0] r_stall_cycles;

    logic w_load_use;
    logic w_freeze_start;
    logic w_waiting;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_id_ex_write;
    logic w_ex_mem_write;
    logic w_bubble;
    logic w_if_id_flush;
    logic w_id_ex_flush;

    assign w_load_use = hif.id_ex_memread && (hif.id_ex_rt != 5'd0) &&
                        ((hif.id_ex_rt == hif.id_rs) || (hif.id_ex_rt == hif.id_rt));

    assign w_freeze_start = (r_state == ST_RUN) && hif.mem_req && !hif.mem_ready;
    assign w_waiting      = (r_state == ST_WAIT) && !hif.mem_ready;

    // Freeze and halt dominate; branch beats load-use once the memory is free.
    always_comb begin
        w_pc_write     = 1'b0;
        w_if_id_write  = 1'b0;
        w_id_ex_write  = 1'b0;
        w_ex_mem_write = 1'b0;
        w_bubble       = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        if (!reset && (r_state != ST_HALT) && !w_freeze_start && !w_waiting) begin
            if (hif.branch_taken) begin
                w_pc_write     = 1'b1;
                w_if_id_write  = 1'b1;
                w_id_ex_write  = 1'b1;
                w_ex_mem_write = 1'b1;
                w_if_id_flush  = 1'b1;
                w_id_ex_flush  = 1'b1;
            end else if (w_load_use) begin
                w_id_ex_write  = 1'b1;
                w_ex_mem_write = 1'b1;
                w_bubble       = 1'b1;
            end else begin
                w_pc_write     = 1'b1;
                w_if_id_write  = 1'b1;
                w_id_ex_write  = 1'b1;
                w_ex_mem_write = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_RUN;
            r_wait_cnt     <= 8'd0;
            r_mem_timeout  <= 1'b0;
            r_stall_cycles <= 16'd0;
        end else begin
            if (!w_pc_write && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            case (r_state)
                ST_RUN: begin
                    if (w_freeze_start) begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                ST_WAIT: begin
                    if (hif.mem_ready) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= 8'd0;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state       <= ST_HALT;
                        r_mem_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    assign hif.pc_write     = w_pc_write;
    assign hif.if_id_write  = w_if_id_write;
    assign hif.id_ex_write  = w_id_ex_write;
    assign hif.ex_mem_write = w_ex_mem_write;
    assign hif.id_ex_bubble = w_bubble;
    assign hif.if_id_flush  = w_if_id_flush;
    assign hif.id_ex_flush  = w_id_ex_flush;
    assign hif.mem_timeout  = r_mem_timeout;
    assign hif.stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl with a behavioural model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_hazard_ctrl;

    localparam int c_TIMEOUT = 4;

    logic clk;
    logic rst;

    hazard_ctrl_if hif ();

    hazard_ctrl #(.TIMEOUT(c_TIMEOUT)) dut (
        .clk   (clk),
        .reset (rst),
        .hif   (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] v;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Model: memory-stall depth (0 = not waiting), halted, sticky timeout, counter.
    int m_wait_depth = 0;
    bit m_halted     = 0;
    bit m_tmo        = 0;
    int m_stall      = 0;

    // Field order: pc, ifid, idex, exmem, bubble, ifid_flush, idex_flush, timeout, stall[15:0]
    task automatic step(input bit r, input int rs, input int rt, input bit rd,
                        input int xrt, input bit br, input bit mq, input bit mr,
                        input string name);
        bit   lu;
        bit   pc, ifw, idw, exw, bub, ff, fx;
        exp_t e;
        rst = r;
        hif.id_rs = 5'(rs);
        hif.id_rt = 5'(rt);
        hif.id_ex_memread = rd;
        hif.id_ex_rt = 5'(xrt);
        hif.branch_taken = br;
        hif.mem_req = mq;
        hif.mem_ready = mr;

        lu = rd && (xrt != 0) && (xrt == rs || xrt == rt);
        {pc, ifw, idw, exw, bub, ff, fx} = '0;
        if (r || m_halted) begin
            // frozen, nothing asserted
        end else if (m_wait_depth == 0 && mq && !mr) begin
            // freeze begins
        end else if (m_wait_depth > 0 && !mr) begin
            // still frozen
        end else if (br) begin
            {pc, ifw, idw, exw, ff, fx} = 6'b111111;
        end else if (lu) begin
            {idw, exw, bub} = 3'b111;
        end else begin
            {pc, ifw, idw, exw} = 4'b1111;
        end
        e.v = {pc, ifw, idw, exw, bub, ff, fx, m_tmo, 16'(m_stall)};
        e.name = name;
        q.push_back(e);

        if (r) begin
            m_wait_depth = 0; m_halted = 0; m_tmo = 0; m_stall = 0;
        end else begin
            if (!pc && m_stall < 65535) m_stall++;
            if (!m_halted) begin
                if (m_wait_depth == 0) begin
                    if (mq && !mr) m_wait_depth = 1;
                end else if (mr) begin
                    m_wait_depth = 0;
                end else if (m_wait_depth == c_TIMEOUT - 1) begin
                    m_halted = 1; m_tmo = 1; m_wait_depth = 0;
                end else begin
                    m_wait_depth++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are valid every cycle; compare away from the edge.
    initial begin
        exp_t        e;
        logic [23:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                act = {hif.pc_write, hif.if_id_write, hif.id_ex_write, hif.ex_mem_write,
                       hif.id_ex_bubble, hif.if_id_flush, hif.id_ex_flush,
                       hif.mem_timeout, hif.stall_cycles};
                n_vec++;
                if (act !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got ctl=%b tmo=%b stall=%0d, want ctl=%b tmo=%b stall=%0d",
                             e.name, act[23:17], act[16], act[15:0], e.v[23:17], e.v[16], e.v[15:0]);
                end
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1;
        hif.id_rs = '0; hif.id_rt = '0; hif.id_ex_memread = 1'b0; hif.id_ex_rt = '0;
        hif.branch_taken = 1'b0; hif.mem_req = 1'b0; hif.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        step(1, 0, 0, 0, 0, 0, 0, 0, "reset_state");
        step(0, 1, 2, 0, 0, 0, 0, 0, "first_run");

        // load-use on rs, then normal
        step(0, 5, 7, 1, 5, 0, 0, 0, "load_use");
        step(0, 5, 7, 0, 5, 0, 0, 0, "after_load_use");
        step(0, 5, 7, 0, 5, 0, 0, 0, "stall_count_1");
        // register zero never stalls
        step(0, 3, 0, 1, 0, 0, 0, 0, "reg_zero");
        // branch beats load-use
        step(0, 9, 4, 1, 4, 1, 0, 0, "branch_over_lu");

        // branch held during a three-cycle freeze
        step(1, 0, 0, 0, 0, 0, 0, 0, "reset_b");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 1, 0, "freeze_branch");
        step(0, 0, 0, 0, 0, 1, 1, 1, "freeze_release");
        step(0, 0, 0, 0, 0, 0, 0, 0, "freeze_stall3");

        // timeout into halt, ready ignored, reset recovers
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1, 0, "timeout");
        for (int i = 0; i < 3; i++) step(0, 2, 2, 1, 2, 1, 1, 1, "halt_hold");
        step(1, 0, 0, 0, 0, 0, 0, 0, "halt_reset");
        step(0, 0, 0, 0, 0, 0, 0, 0, "post_halt");

        // reset mid-wait leaves no residual freeze
        step(0, 0, 0, 0, 0, 0, 1, 0, "mid_wait");
        step(1, 0, 0, 0, 0, 0, 1, 0, "mid_wait_reset");
        step(0, 0, 0, 0, 0, 0, 0, 0, "mid_wait_after");

        // randomized traffic with narrow register range to provoke matches
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 3), ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 55), "random");
        end

        // saturation: hold load-use for more than 65535 cycles
        step(1, 0, 0, 0, 0, 0, 0, 0, "sat_reset");
        for (int i = 0; i < 65540; i++) step(0, 6, 1, 1, 6, 0, 0, 0, "saturate");
        step(0, 6, 1, 1, 6, 0, 0, 0, "saturate_hold");

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
